// File: rtl/pmp_scan_unit.sv
// PMP checker: per-entry cfg/addr registers plus a multi-cycle scan that examines
// LANES entries per cycle and reports the lowest-index matching entry and fault.
module pmp_scan_unit #(
    parameter int N_ENTRIES = 16,
    parameter int LANES     = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic        csr_sel,
    input  logic [3:0]  csr_idx,
    input  logic [31:0] csr_wdata,
    output logic        csr_busy,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_oper,
    input  logic [1:0]  req_priv,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_fault,
    output logic [1:0]  resp_oper,
    output logic [4:0]  resp_entry
);
    // state | meaning
    // IDLE  | waiting for a request, CSR writes allowed
    // SCAN  | evaluating entries ptr..ptr+LANES-1 each cycle
    // RESP  | holding the response until resp_ready
    localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, RESP = 2'd2} state_t;

    state_t        state;
    logic [7:0]    cfg  [N_ENTRIES];
    logic [31:0]   addr [N_ENTRIES];
    logic [IW-1:0] ptr;
    logic [31:0]   q_addr;
    logic [1:0]    q_size;
    logic [1:0]    q_oper;
    logic [1:0]    q_priv;

    function automatic logic in_region(input logic [33:0] w, input logic [1:0] mode,
                                       input logic [31:0] cur, input logic [31:0] prev);
        logic [33:0] mask;
        logic [33:0] base;
        // mask covers the trailing ones plus the first zero: region spans mask+1 words
        mask = {2'b0, cur} ^ ({2'b0, cur} + 34'd1);
        base = {2'b0, cur} & ~mask;
        case (mode)
            2'b01:   in_region = (w >= {2'b0, prev}) && (w < {2'b0, cur});
            2'b10:   in_region = (w == {2'b0, cur});
            2'b11:   in_region = (w >= base) && (w <= base + mask);
            default: in_region = 1'b0;
        endcase
    endfunction

    function automatic logic calc_fault(input logic m, input logic part, input logic [7:0] c,
                                        input logic [1:0] oper, input logic [1:0] priv);
        if (oper == 2'b11)                 calc_fault = 1'b1;
        else if (!m)                       calc_fault = (priv != 2'b11);
        else if (part)                     calc_fault = 1'b1;
        else if (priv == 2'b11 && !c[7])   calc_fault = 1'b0;
        else if (oper == 2'b00)            calc_fault = !c[0];
        else if (oper == 2'b01)            calc_fault = !c[1];
        else                               calc_fault = !c[2];
    endfunction

    logic [IW-1:0] widx;
    logic [IW-1:0] nidx;
    logic          idx_ok;
    logic          tgt_locked;
    logic          next_tor_locked;
    logic          csr_ok;

    assign widx            = csr_idx[IW-1:0];
    assign nidx            = widx + IW'(1);
    assign idx_ok          = int'(csr_idx) < N_ENTRIES;
    assign tgt_locked      = idx_ok && cfg[widx][7];
    assign next_tor_locked = (int'(csr_idx) + 1 < N_ENTRIES) && cfg[nidx][7] && (cfg[nidx][4:3] == 2'b01);
    assign csr_ok          = csr_we && idx_ok && !tgt_locked && !csr_busy && !(csr_sel && next_tor_locked);

    // word indices of the first and last byte; the last byte is formed without wrap
    logic [33:0] first_w;
    logic [33:0] last_w;
    assign first_w = {2'b0, q_addr} >> 2;
    assign last_w  = ({2'b0, q_addr} + ((34'd1 << q_size) - 34'd1)) >> 2;

    logic          hit;
    logic          hit_part;
    logic [IW-1:0] hit_idx;
    logic [IW-1:0] e_l;
    logic [31:0]   prev_l;
    logic          f_in;
    logic          l_in;

    always_comb begin
        hit      = 1'b0;
        hit_part = 1'b0;
        hit_idx  = '0;
        e_l      = '0;
        prev_l   = '0;
        f_in     = 1'b0;
        l_in     = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            e_l    = ptr + IW'(l);
            prev_l = (e_l == '0) ? 32'd0 : addr[e_l - IW'(1)];
            f_in   = in_region(first_w, cfg[e_l][4:3], addr[e_l], prev_l);
            l_in   = in_region(last_w, cfg[e_l][4:3], addr[e_l], prev_l);
            if (!hit && (f_in || l_in)) begin
                hit      = 1'b1;
                hit_idx  = e_l;
                hit_part = f_in ^ l_in;
            end
        end
    end

    logic [7:0] hit_cfg;
    logic       scan_fault;
    logic       last_group;
    assign hit_cfg    = cfg[hit_idx];
    assign scan_fault = calc_fault(hit, hit_part, hit_cfg, q_oper, q_priv);
    assign last_group = (int'(ptr) + LANES >= N_ENTRIES);

    assign req_ready  = (state == IDLE);
    assign csr_busy   = (state != IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            q_addr     <= '0;
            q_size     <= '0;
            q_oper     <= '0;
            q_priv     <= '0;
            resp_fault <= 1'b0;
            resp_oper  <= 2'b00;
            resp_entry <= 5'd16;
            for (int i = 0; i < N_ENTRIES; i++) begin
                cfg[i]  <= '0;
                addr[i] <= '0;
            end
        end else begin
            if (csr_ok) begin
                if (csr_sel) addr[widx] <= csr_wdata;
                else         cfg[widx]  <= csr_wdata[7:0];
            end
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        q_addr <= req_addr;
                        q_size <= req_size;
                        q_oper <= req_oper;
                        q_priv <= req_priv;
                        ptr    <= '0;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit || last_group) begin
                        resp_entry <= hit ? 5'(hit_idx) : 5'd16;
                        resp_fault <= scan_fault;
                        resp_oper  <= q_oper;
                        state      <= RESP;
                    end else begin
                        ptr <= ptr + IW'(LANES);
                    end
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pmp_scan_unit.md
PMP_SCAN_UNIT -- requirements
Module: pmp_scan_unit

Interface
REQ-001 SHALL have parameter N_ENTRIES, default 16, number of PMP entries (legal 1..16).
REQ-002 SHALL have parameter LANES, default 4, entries examined per scan cycle (legal 1, 2, 4, 8 or 16; N_ENTRIES multiple of LANES).
REQ-003 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have CSR ports: csr_we input 1, write strobe; csr_sel input 1 (0 = pmpcfg byte, 1 = pmpaddr); csr_idx input 4, entry index; csr_wdata input 32, write data; csr_busy output 1, high while a check is in flight.
REQ-005 SHALL have request ports: req_valid input 1; req_ready output 1; req_addr input 32, byte address; req_size input 2 (00 byte, 01 half, 10 word); req_oper input 2 (00 read, 01 write, 10 execute); req_priv input 2 (00 U, 01 S, 11 M).
REQ-006 SHALL have response ports: resp_valid output 1; resp_ready input 1; resp_fault output 1; resp_oper output 2, echo of req_oper; resp_entry output 5, matching entry index or 16 for no match.

Function
REQ-007 SHALL hold per entry an 8-bit cfg register {L, 00, A[1:0], X, W, R} and a 32-bit addr register encoding byte address bits [33:2].
REQ-008 SHALL update cfg (wdata[7:0]) or addr (wdata[31:0]) of entry csr_idx on csr_we in the cycle after the strobe.
REQ-009 SHALL drop a CSR write when csr_idx >= N_ENTRIES, when the target entry has L=1, or when csr_busy=1.
REQ-010 SHALL drop a pmpaddr write to entry i when entry i+1 has L=1 and A=TOR.
REQ-011 SHALL implement states IDLE, SCAN, RESP; req_ready=1 only in IDLE; csr_busy=1 in SCAN and RESP.
REQ-012 SHALL capture req_addr/size/oper/priv on req_valid&&req_ready and enter SCAN with scan pointer 0.
REQ-013 SHALL in each SCAN cycle evaluate entries ptr..ptr+LANES-1, then advance ptr by LANES.
REQ-014 SHALL decode A: 00 OFF (never matches); 01 TOR, match when addr[i-1] <= a[33:2] < addr[i] (lower bound 0 for entry 0); 10 NA4, match when a[33:2] == addr[i]; 11 NAPOT, region given by trailing ones of addr[i] (k ones = 2^(k+3) bytes).
REQ-015 SHALL treat an entry as matched only if first byte and last byte (req_addr + 2^size - 1, computed in 33 bits, no wrap) both lie in it; exactly one byte inside SHALL count as a match with fault forced.
REQ-016 SHALL select the lowest-index matching entry; a match in a lane group SHALL terminate the scan and move to RESP the next cycle.
REQ-017 SHALL move to RESP after the last group with resp_entry=16 when nothing matched.
REQ-018 SHALL compute resp_fault: no match -> fault iff priv != M; match with priv = M and L=0 -> no fault; otherwise fault iff the R/W/X bit selected by oper is 0; oper=11 always faults.
REQ-019 SHALL hold resp_valid and all resp_* stable in RESP until resp_ready=1, then return to IDLE the next cycle.
REQ-020 SHALL give latency from accept to resp_valid of g+1 cycles, where g is the 1-based index of the lane group ending the scan (max N_ENTRIES/LANES + 1).
REQ-021 SHALL ignore req_valid outside IDLE; simultaneous resp handshake and new req_valid SHALL accept the new request only after IDLE is reached.

Reset
REQ-022 SHALL on rst_n=0, asynchronously, clear all cfg and addr registers to 0, state to IDLE, ptr to 0.
REQ-023 SHALL drive after reset: req_ready=1, csr_busy=0, resp_valid=0, resp_fault=0, resp_oper=0, resp_entry=16.
REQ-024 SHALL abort any in-flight check on reset with no response issued.

Verification
REQ-025 Reset state: no entries configured, U-mode read 0x1000 -> resp_entry=16, resp_fault=1; M-mode read -> resp_fault=0.
REQ-026 TOR priority: entry0 TOR addr=0x400 (bytes 0..0xFFF) R=1, entry1 TOR addr=0x800 W=1; U-mode write 0x1004 -> entry 1, fault=0, latency 2 (LANES=4).
REQ-027 NAPOT straddle: entry5 NAPOT 0x1000..0x1007 (addr=0x400) R=1; U-mode word read at 0x1006 -> resp_entry=5, resp_fault=1.
REQ-028 Lock: entry3 cfg written L=1,R=0; later cfg/addr writes to entry3 dropped; M-mode read in region -> fault=1; addr write to entry2 dropped when entry3 is TOR.
REQ-029 Back-pressure/latency: N_ENTRIES=16, LANES=1, match only entry 15; resp_valid after 17 cycles, held 5 cycles with resp_ready=0, csr write during hold dropped, req_ready=0 throughout.
REQ-030 Reset mid-scan: assert rst_n=0 in SCAN -> resp_valid=0, req_ready=1, all entries cleared.
